// File: rtl/juice_vend_if.sv
// Front-end / actuator signal bundle for the juice vending controller.
// master = coin/keypad front end and dispenser model, slave = controller.
interface juice_vend_if #(
  parameter int CREDIT_W = 4
);
  logic                coin_valid;
  logic [2:0]          coin_value;
  logic                sel_valid;
  logic [1:0]          sel;
  logic                cancel;
  logic                disp_done;
  logic                disp_req_1;
  logic                disp_req_2;
  logic                change_pulse;
  logic [CREDIT_W-1:0] credit;
  logic                reject;
  logic                fault;
  logic                busy;

  modport master (
    output coin_valid, coin_value, sel_valid, sel, cancel, disp_done,
    input  disp_req_1, disp_req_2, change_pulse, credit, reject, fault, busy
  );

  modport slave (
    input  coin_valid, coin_value, sel_valid, sel, cancel, disp_done,
    output disp_req_1, disp_req_2, change_pulse, credit, reject, fault, busy
  );
endinterface

// File: rtl/juice_vend_controller.sv
// Juice vending sequencer: coin credit, product selection, dispenser
// request/done handshake with timeout, and one-unit-at-a-time change payout.
module juice_vend_controller #(
  parameter int PRICE_1    = 1,
  parameter int PRICE_2    = 2,
  parameter int CREDIT_W   = 4,
  parameter int MAX_CREDIT = 9,
  parameter int TIMEOUT    = 16
) (
  input  logic       clk,
  input  logic       reset,
  juice_vend_if.slave bus
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CREDIT_W-1:0] PRICE1_C = CREDIT_W'(PRICE_1);
  localparam logic [CREDIT_W-1:0] PRICE2_C = CREDIT_W'(PRICE_2);
  localparam logic [CREDIT_W-1:0] ONE_C    = CREDIT_W'(1);
  localparam logic [CREDIT_W:0]   MAX_C    = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ACCUM        = 2'd0,
    DISPENSE     = 2'd1,
    CHANGE_PULSE = 2'd2,
    CHANGE_GAP   = 2'd3
  } state_t;

  state_t              state_reg;
  logic [CREDIT_W-1:0] credit_reg;
  logic [CREDIT_W-1:0] price_reg;
  logic [CNT_W-1:0]    timer_reg;
  logic                disp_req_1_reg;
  logic                disp_req_2_reg;
  logic                change_pulse_reg;
  logic                reject_reg;
  logic                fault_reg;
  logic                busy_reg;

  // One bit wider than the credit so an oversized coin cannot wrap.
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_legal;
  logic                sel_legal;
  logic [CREDIT_W-1:0] sel_price;

  assign coin_sum   = {1'b0, credit_reg} + (CREDIT_W+1)'(bus.coin_value);
  assign coin_legal = (bus.coin_value == 3'd1) || (bus.coin_value == 3'd2) ||
                      (bus.coin_value == 3'd5);

  always_comb begin
    sel_legal = 1'b0;
    sel_price = '0;
    case (bus.sel)
      2'b01: begin
        sel_legal = 1'b1;
        sel_price = PRICE1_C;
      end
      2'b10: begin
        sel_legal = 1'b1;
        sel_price = PRICE2_C;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ACCUM;
      credit_reg       <= '0;
      price_reg        <= '0;
      timer_reg        <= '0;
      disp_req_1_reg   <= 1'b0;
      disp_req_2_reg   <= 1'b0;
      change_pulse_reg <= 1'b0;
      reject_reg       <= 1'b0;
      fault_reg        <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      reject_reg       <= 1'b0;
      fault_reg        <= 1'b0;
      change_pulse_reg <= 1'b0;
      case (state_reg)
        ACCUM: begin
          if (bus.cancel && (credit_reg != '0)) begin
            state_reg <= CHANGE_PULSE;
            busy_reg  <= 1'b1;
          end else if (bus.coin_valid) begin
            // A selection in the same cycle as a coin is dropped silently.
            if (coin_legal && (coin_sum <= MAX_C)) begin
              credit_reg <= coin_sum[CREDIT_W-1:0];
            end else begin
              reject_reg <= 1'b1;
            end
          end else if (bus.sel_valid && !bus.cancel) begin
            if (!sel_legal || (credit_reg < sel_price)) begin
              reject_reg <= 1'b1;
            end else begin
              credit_reg     <= credit_reg - sel_price;
              price_reg      <= sel_price;
              disp_req_1_reg <= (bus.sel == 2'b01);
              disp_req_2_reg <= (bus.sel == 2'b10);
              timer_reg      <= '0;
              state_reg      <= DISPENSE;
              busy_reg       <= 1'b1;
            end
          end
        end
        DISPENSE: begin
          reject_reg <= bus.coin_valid;
          if (bus.disp_done) begin
            disp_req_1_reg <= 1'b0;
            disp_req_2_reg <= 1'b0;
            timer_reg      <= '0;
            state_reg      <= (credit_reg != '0) ? CHANGE_PULSE : ACCUM;
            busy_reg       <= (credit_reg != '0);
          end else if (timer_reg == CNT_LAST) begin
            // Dispenser never answered: refund the price and pay it all back.
            disp_req_1_reg <= 1'b0;
            disp_req_2_reg <= 1'b0;
            timer_reg      <= '0;
            credit_reg     <= credit_reg + price_reg;
            fault_reg      <= 1'b1;
            state_reg      <= CHANGE_PULSE;
          end else begin
            timer_reg <= timer_reg + CNT_W'(1);
          end
        end
        CHANGE_PULSE: begin
          reject_reg       <= bus.coin_valid;
          change_pulse_reg <= 1'b1;
          credit_reg       <= credit_reg - ONE_C;
          state_reg        <= CHANGE_GAP;
        end
        CHANGE_GAP: begin
          reject_reg <= bus.coin_valid;
          state_reg  <= (credit_reg != '0) ? CHANGE_PULSE : ACCUM;
          busy_reg   <= (credit_reg != '0);
        end
        default: begin
          state_reg      <= ACCUM;
          credit_reg     <= '0;
          timer_reg      <= '0;
          disp_req_1_reg <= 1'b0;
          disp_req_2_reg <= 1'b0;
          busy_reg       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.disp_req_1   = disp_req_1_reg;
  assign bus.disp_req_2   = disp_req_2_reg;
  assign bus.change_pulse = change_pulse_reg;
  assign bus.credit       = credit_reg;
  assign bus.reject       = reject_reg;
  assign bus.fault        = fault_reg;
  assign bus.busy         = busy_reg;
endmodule

// File: tb/tb_juice_vend_controller.sv
// Self-checking bench for juice_vend_controller: directed scenarios plus a
// randomized purchase loop checked against a transaction-level credit model.
module tb_juice_vend_controller;
  localparam int P1      = 1;
  localparam int P2      = 2;
  localparam int MAXC    = 9;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   m_credit = 0;

  juice_vend_if #(.CREDIT_W(4)) bus ();

  juice_vend_controller #(
    .PRICE_1(P1), .PRICE_2(P2), .CREDIT_W(4), .MAX_CREDIT(MAXC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.coin_valid = 1'b0;
    bus.coin_value = 3'd0;
    bus.sel_valid  = 1'b0;
    bus.sel        = 2'b00;
    bus.cancel     = 1'b0;
    bus.disp_done  = 1'b0;
  endtask

  task automatic coin(input int v);
    bus.coin_valid = 1'b1;
    bus.coin_value = 3'(v);
    step();
    bus.coin_valid = 1'b0;
  endtask

  // Observe a payout of n units until the controller goes idle again.
  task automatic drain(input int n, input bit inject, input string tag);
    int pulses = 0, last = -1, gap_bad = 0, cyc = 0, rej = 0, flt = 0;
    bit injected = 1'b0;
    while (cyc < 4 * n + 20) begin
      if (inject && !injected && pulses == 1) begin
        bus.coin_valid = 1'b1;
        bus.coin_value = 3'd1;
        injected = 1'b1;
      end
      step();
      bus.coin_valid = 1'b0;
      cyc++;
      if (bus.reject) rej++;
      if (bus.fault) flt++;
      if (bus.change_pulse) begin
        if (last >= 0 && cyc - last != 2) gap_bad++;
        last = cyc;
        pulses++;
      end
      if (!bus.busy) break;
    end
    checks++;
    if (pulses !== n) begin
      failures++;
      $display("FAIL %s pulses: got %0d expected %0d", tag, pulses, n);
    end
    checks++;
    if (gap_bad !== 0) begin
      failures++;
      $display("FAIL %s pulse_spacing: got %0d bad gaps expected 0", tag, gap_bad);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.credit !== 4'd0) begin
      failures++;
      $display("FAIL %s end_state: busy=%b credit=%0d expected busy=0 credit=0",
               tag, bus.busy, bus.credit);
    end
    checks++;
    if (flt !== 0) begin
      failures++;
      $display("FAIL %s fault_during_payout: got %0d expected 0", tag, flt);
    end
    if (inject) begin
      checks++;
      if (rej !== 1) begin
        failures++;
        $display("FAIL %s payout_coin_reject: got %0d expected 1", tag, rej);
      end
    end
    m_credit = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    bus.coin_valid = 1'b1;
    bus.coin_value = 3'd5;
    repeat (3) step();
    bus.coin_valid = 1'b0;
    reset = 1'b0;
    m_credit = 0;
    checks++;
    if ({bus.credit, bus.busy, bus.disp_req_1, bus.disp_req_2, bus.change_pulse,
         bus.reject, bus.fault} !== 10'd0) begin
      failures++;
      $display("FAIL reset_state: credit=%0d busy=%b req=%b%b chg=%b rej=%b flt=%b expected all 0",
               bus.credit, bus.busy, bus.disp_req_1, bus.disp_req_2, bus.change_pulse,
               bus.reject, bus.fault);
    end
  endtask

  task automatic test_coins();
    coin(2);
    coin(5);
    checks++;
    if (bus.credit !== 4'd7 || bus.busy !== 1'b0 || bus.reject !== 1'b0) begin
      failures++;
      $display("FAIL coins_2_5: credit=%0d busy=%b reject=%b expected 7 0 0",
               bus.credit, bus.busy, bus.reject);
    end
    coin(5);
    checks++;
    if (bus.reject !== 1'b1 || bus.credit !== 4'd7) begin
      failures++;
      $display("FAIL coin_overflow: reject=%b credit=%0d expected 1 7", bus.reject, bus.credit);
    end
    step();
    checks++;
    if (bus.reject !== 1'b0) begin
      failures++;
      $display("FAIL reject_single_pulse: got %b expected 0", bus.reject);
    end
    coin(3);
    checks++;
    if (bus.reject !== 1'b1 || bus.credit !== 4'd7) begin
      failures++;
      $display("FAIL coin_illegal: reject=%b credit=%0d expected 1 7", bus.reject, bus.credit);
    end
    m_credit = 7;
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    drain(7, 1'b0, "cancel7");
  endtask

  task automatic test_dispense();
    coin(1);
    coin(2);
    bus.sel_valid = 1'b1;
    bus.sel = 2'b10;
    step();
    bus.sel_valid = 1'b0;
    checks++;
    if (bus.disp_req_2 !== 1'b1 || bus.disp_req_1 !== 1'b0 || bus.credit !== 4'd1 ||
        bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL sel2_accept: req1=%b req2=%b credit=%0d busy=%b expected 0 1 1 1",
               bus.disp_req_1, bus.disp_req_2, bus.credit, bus.busy);
    end
    // Cancel and a new selection while dispensing are ignored.
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    bus.sel_valid = 1'b1;
    bus.sel = 2'b01;
    step();
    bus.sel_valid = 1'b0;
    repeat (2) step();
    checks++;
    if (bus.disp_req_2 !== 1'b1 || bus.disp_req_1 !== 1'b0 || bus.credit !== 4'd1 ||
        bus.change_pulse !== 1'b0) begin
      failures++;
      $display("FAIL dispense_hold: req1=%b req2=%b credit=%0d chg=%b expected 0 1 1 0",
               bus.disp_req_1, bus.disp_req_2, bus.credit, bus.change_pulse);
    end
    bus.disp_done = 1'b1;
    step();
    bus.disp_done = 1'b0;
    checks++;
    if (bus.disp_req_2 !== 1'b0 || bus.fault !== 1'b0) begin
      failures++;
      $display("FAIL done_release: req2=%b fault=%b expected 0 0", bus.disp_req_2, bus.fault);
    end
    drain(1, 1'b0, "dispense_change");
  endtask

  task automatic test_sel_reject();
    coin(1);
    bus.sel_valid = 1'b1;
    bus.sel = 2'b10;
    step();
    bus.sel_valid = 1'b0;
    checks++;
    if (bus.reject !== 1'b1 || bus.disp_req_2 !== 1'b0 || bus.credit !== 4'd1 ||
        bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL sel_short_credit: reject=%b req2=%b credit=%0d busy=%b expected 1 0 1 0",
               bus.reject, bus.disp_req_2, bus.credit, bus.busy);
    end
    bus.sel_valid = 1'b1;
    bus.sel = 2'b01;
    coin(1);
    bus.sel_valid = 1'b0;
    checks++;
    if (bus.credit !== 4'd2 || bus.reject !== 1'b0 || bus.disp_req_1 !== 1'b0 ||
        bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL coin_with_sel: credit=%0d reject=%b req1=%b busy=%b expected 2 0 0 0",
               bus.credit, bus.reject, bus.disp_req_1, bus.busy);
    end
    m_credit = 2;
  endtask

  task automatic test_timeout();
    int fault_at = -1;
    int req_early_drop = 0;
    bus.sel_valid = 1'b1;
    bus.sel = 2'b01;
    step();
    bus.sel_valid = 1'b0;
    for (int k = 1; k <= TIMEOUT + 8; k++) begin
      step();
      if (bus.fault) begin
        fault_at = k;
        break;
      end
      if (bus.disp_req_1 !== 1'b1) req_early_drop++;
    end
    checks++;
    if (fault_at !== TIMEOUT) begin
      failures++;
      $display("FAIL timeout_fault_cycle: got %0d expected %0d", fault_at, TIMEOUT);
    end
    checks++;
    if (req_early_drop !== 0 || bus.disp_req_1 !== 1'b0 || bus.credit !== 4'd2) begin
      failures++;
      $display("FAIL timeout_release: early_drops=%0d req1=%b credit=%0d expected 0 0 2",
               req_early_drop, bus.disp_req_1, bus.credit);
    end
    drain(2, 1'b0, "timeout_refund");
  endtask

  task automatic test_cancel_and_reset();
    coin(5);
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    drain(5, 1'b1, "cancel5");
    coin(2);
    coin(2);
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (bus.credit !== 4'd0 || bus.busy !== 1'b0 || bus.change_pulse !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_payout: credit=%0d busy=%b chg=%b expected 0 0 0",
               bus.credit, bus.busy, bus.change_pulse);
    end
    repeat (2) step();
    checks++;
    if (bus.change_pulse !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL after_reset_idle: chg=%b busy=%b expected 0 0", bus.change_pulse, bus.busy);
    end
    m_credit = 0;
  endtask

  task automatic test_random_purchases();
    int coin_tab[6] = '{1, 2, 5, 1, 2, 3};
    for (int it = 0; it < 12; it++) begin
      int ncoins = $urandom_range(1, 4);
      for (int c = 0; c < ncoins; c++) begin
        int v = coin_tab[$urandom_range(0, 5)];
        bit ok;
        if ($urandom_range(0, 9) == 0) v = 0;
        ok = (v == 1 || v == 2 || v == 5) && (m_credit + v <= MAXC);
        if (ok) m_credit += v;
        coin(v);
        checks++;
        if (bus.credit !== 4'(m_credit) || bus.reject !== !ok) begin
          failures++;
          $display("FAIL rand_coin it=%0d v=%0d: credit=%0d reject=%b expected %0d %b",
                   it, v, bus.credit, bus.reject, m_credit, !ok);
        end
      end
      begin
        int  pick = $urandom_range(0, 7);
        logic [1:0] s = (pick < 3) ? 2'b01 : (pick < 6) ? 2'b10 : 2'(pick - 6) * 2'd3;
        int  price = (s == 2'b01) ? P1 : P2;
        bit  accept = (s == 2'b01 || s == 2'b10) && (m_credit >= price);
        int  d = (it == 0) ? TIMEOUT - 1 : $urandom_range(0, TIMEOUT + 3);
        int  exit_k = -1;
        bit  done_wins = (d <= TIMEOUT - 1);
        bus.sel_valid = 1'b1;
        bus.sel = s;
        step();
        bus.sel_valid = 1'b0;
        if (!accept) begin
          checks++;
          if (bus.reject !== 1'b1 || bus.busy !== 1'b0 || bus.credit !== 4'(m_credit)) begin
            failures++;
            $display("FAIL rand_sel_reject it=%0d sel=%b: reject=%b busy=%b credit=%0d expected 1 0 %0d",
                     it, s, bus.reject, bus.busy, bus.credit, m_credit);
          end
          continue;
        end
        m_credit -= price;
        checks++;
        if (bus.credit !== 4'(m_credit) || bus.disp_req_1 !== (s == 2'b01) ||
            bus.disp_req_2 !== (s == 2'b10)) begin
          failures++;
          $display("FAIL rand_sel_accept it=%0d sel=%b: credit=%0d req=%b%b expected %0d",
                   it, s, bus.credit, bus.disp_req_1, bus.disp_req_2, m_credit);
        end
        for (int k = 0; k < TIMEOUT + 8; k++) begin
          bus.disp_done = (k == d);
          step();
          bus.disp_done = 1'b0;
          if (!bus.disp_req_1 && !bus.disp_req_2) begin
            exit_k = k;
            break;
          end
        end
        if (!done_wins) m_credit += price;
        checks++;
        if (exit_k !== (done_wins ? d : TIMEOUT - 1) || bus.fault !== !done_wins ||
            bus.credit !== 4'(m_credit)) begin
          failures++;
          $display("FAIL rand_dispense it=%0d d=%0d: exit=%0d fault=%b credit=%0d expected %0d %b %0d",
                   it, d, exit_k, bus.fault, bus.credit, done_wins ? d : TIMEOUT - 1,
                   !done_wins, m_credit);
        end
        if (m_credit > 0) begin
          drain(m_credit, 1'b0, "rand_change");
        end else begin
          checks++;
          if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL rand_no_change it=%0d: busy=%b expected 0", it, bus.busy);
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_coins();
    test_dispense();
    test_sel_reject();
    test_timeout();
    test_cancel_and_reset();
    test_random_purchases();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
